// File: rtl/tl_resp_pkg.sv
// Shared constants, field widths and FSM state type for the TL-UL SRAM responder.
package tl_resp_pkg;
  localparam int unsigned ADDR_W  = 17;
  localparam int unsigned SRC_W   = 7;
  localparam int unsigned DATA_W  = 64;
  localparam int unsigned MASK_W  = DATA_W / 8;
  localparam int unsigned WADDR_W = ADDR_W - 3;

  localparam logic [2:0] A_PUT_FULL    = 3'd0;
  localparam logic [2:0] A_PUT_PARTIAL = 3'd1;
  localparam logic [2:0] A_GET         = 3'd4;
  localparam logic [2:0] A_HINT        = 3'd5;

  localparam logic [2:0] D_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] D_ACCESS_ACK_DATA = 3'd1;
  localparam logic [2:0] D_HINT_ACK        = 3'd2;

  localparam logic [2:0] MAX_SIZE = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_ACK,
    S_RD_ISSUE,
    S_RD_RESP
  } state_e;

  // Index of the final beat: sizes up to 8 bytes are one beat, 4/5/6 give 2/4/8.
  function automatic logic [2:0] last_beat(input logic [2:0] size);
    case (size)
      3'd4:    return 3'd1;
      3'd5:    return 3'd3;
      3'd6:    return 3'd7;
      default: return 3'd0;
    endcase
  endfunction
endpackage

// File: rtl/tl_sram_responder_if.sv
// TL-UL A/D channels plus the single-port SRAM port served by the responder.
interface tl_sram_responder_if;
  import tl_resp_pkg::*;

  logic              a_valid;
  logic              a_ready;
  logic [2:0]        a_opcode;
  logic [2:0]        a_param;
  logic [2:0]        a_size;
  logic [SRC_W-1:0]  a_source;
  logic [ADDR_W-1:0] a_address;
  logic [MASK_W-1:0] a_mask;
  logic [DATA_W-1:0] a_data;
  logic              a_corrupt;

  logic              d_valid;
  logic              d_ready;
  logic [2:0]        d_opcode;
  logic [1:0]        d_param;
  logic [2:0]        d_size;
  logic [SRC_W-1:0]  d_source;
  logic              d_sink;
  logic              d_denied;
  logic [DATA_W-1:0] d_data;
  logic              d_corrupt;

  logic               mem_en;
  logic               mem_we;
  logic [WADDR_W-1:0] mem_addr;
  logic [MASK_W-1:0]  mem_wmask;
  logic [DATA_W-1:0]  mem_wdata;
  logic [DATA_W-1:0]  mem_rdata;

  modport slave (
    input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt,
    output a_ready,
    output d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_data, d_corrupt,
    input  d_ready,
    output mem_en, mem_we, mem_addr, mem_wmask, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt,
    input  a_ready,
    input  d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_data, d_corrupt,
    output d_ready,
    input  mem_en, mem_we, mem_addr, mem_wmask, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/tl_resp_hold.sv
// Read-data path: passes SRAM data through on its valid cycle, then presents a held copy.
module tl_resp_hold
  import tl_resp_pkg::*;
(
  input  logic              clock,
  input  logic              i_capture,
  input  logic [DATA_W-1:0] i_live,
  output logic [DATA_W-1:0] o_data
);
  logic [DATA_W-1:0] r_held;

  always_ff @(posedge clock) begin
    if (i_capture) r_held <= i_live;
  end

  assign o_data = i_capture ? i_live : r_held;
endmodule

// File: rtl/tl_sram_responder.sv
// TL-UL slave in front of a 64-bit single-port SRAM: burst Get/Put, Hint, and denial of the rest.
module tl_sram_responder
  import tl_resp_pkg::*;
(
  input logic                clock,
  input logic                reset,
  tl_sram_responder_if.slave bus
);
  state_e             r_state;
  logic [SRC_W-1:0]   r_source;
  logic [2:0]         r_size;
  logic [WADDR_W-1:0] r_base;
  logic [2:0]         r_beat;
  logic [2:0]         r_last;
  logic               r_a_ready;
  logic               r_d_valid;
  logic [2:0]         r_d_opcode;
  logic               r_d_denied;
  logic               r_rd_en;
  logic               r_first;

  logic               w_a_fire;
  logic               w_d_fire;
  logic               w_size_ok;
  logic               w_is_get;
  logic               w_is_put;
  logic               w_wr;
  logic [WADDR_W-1:0] w_addr;
  logic [DATA_W-1:0]  w_rd_data;
  logic               w_unused_ok;

  assign w_size_ok = (bus.a_size <= MAX_SIZE);
  assign w_is_get  = (bus.a_opcode == A_GET) && w_size_ok;
  assign w_is_put  = ((bus.a_opcode == A_PUT_FULL) || (bus.a_opcode == A_PUT_PARTIAL)) && w_size_ok;
  assign w_a_fire  = bus.a_valid && bus.a_ready;
  assign w_d_fire  = bus.d_valid && bus.d_ready;

  // Put beats write in their acceptance cycle; the first beat's address comes straight off A.
  assign w_wr   = w_a_fire && (((r_state == S_IDLE) && w_is_put) || (r_state == S_WRITE));
  assign w_addr = (r_state == S_IDLE) ? bus.a_address[ADDR_W-1:3]
                                      : r_base + {{(WADDR_W-3){1'b0}}, r_beat};

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_beat     <= '0;
      r_a_ready  <= 1'b1;
      r_d_valid  <= 1'b0;
      r_d_opcode <= D_ACCESS_ACK;
      r_d_denied <= 1'b0;
      r_rd_en    <= 1'b0;
      r_first    <= 1'b0;
    end else begin
      r_first <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_a_fire) begin
            r_source   <= bus.a_source;
            r_size     <= bus.a_size;
            r_base     <= bus.a_address[ADDR_W-1:3];
            r_beat     <= '0;
            r_last     <= last_beat(bus.a_size);
            r_d_denied <= 1'b0;
            if (w_is_get) begin
              r_state    <= S_RD_ISSUE;
              r_a_ready  <= 1'b0;
              r_rd_en    <= 1'b1;
              r_d_opcode <= D_ACCESS_ACK_DATA;
            end else if (w_is_put) begin
              r_d_opcode <= D_ACCESS_ACK;
              if (last_beat(bus.a_size) != 3'd0) begin
                r_state <= S_WRITE;
                r_beat  <= 3'd1;
              end else begin
                r_state   <= S_ACK;
                r_a_ready <= 1'b0;
                r_d_valid <= 1'b1;
              end
            end else begin
              r_state   <= S_ACK;
              r_a_ready <= 1'b0;
              r_d_valid <= 1'b1;
              if ((bus.a_opcode == A_HINT) && w_size_ok) begin
                r_d_opcode <= D_HINT_ACK;
              end else begin
                r_d_opcode <= D_ACCESS_ACK;
                r_d_denied <= 1'b1;
              end
            end
          end
        end
        S_WRITE: begin
          if (w_a_fire) begin
            if (r_beat == r_last) begin
              r_state   <= S_ACK;
              r_a_ready <= 1'b0;
              r_d_valid <= 1'b1;
            end else begin
              r_beat <= r_beat + 3'd1;
            end
          end
        end
        S_ACK: begin
          if (w_d_fire) begin
            r_state   <= S_IDLE;
            r_d_valid <= 1'b0;
            r_a_ready <= 1'b1;
          end
        end
        S_RD_ISSUE: begin
          r_state   <= S_RD_RESP;
          r_rd_en   <= 1'b0;
          r_d_valid <= 1'b1;
          r_first   <= 1'b1;
        end
        S_RD_RESP: begin
          if (w_d_fire) begin
            r_d_valid <= 1'b0;
            if (r_beat == r_last) begin
              r_state   <= S_IDLE;
              r_a_ready <= 1'b1;
            end else begin
              r_state <= S_RD_ISSUE;
              r_beat  <= r_beat + 3'd1;
              r_rd_en <= 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  tl_resp_hold u_hold (
    .clock     (clock),
    .i_capture (r_first),
    .i_live    (bus.mem_rdata),
    .o_data    (w_rd_data)
  );

  // Handshake and memory strobes are masked during reset so an abandoned burst emits nothing.
  assign bus.a_ready   = r_a_ready && !reset;
  assign bus.d_valid   = r_d_valid && !reset;
  assign bus.d_opcode  = r_d_opcode;
  assign bus.d_param   = '0;
  assign bus.d_size    = r_size;
  assign bus.d_source  = r_source;
  assign bus.d_sink    = 1'b0;
  assign bus.d_denied  = r_d_denied;
  assign bus.d_data    = (r_state == S_RD_RESP) ? w_rd_data : '0;
  assign bus.d_corrupt = r_d_denied && (r_d_opcode == D_ACCESS_ACK_DATA);

  assign bus.mem_en    = (w_wr || r_rd_en) && !reset;
  assign bus.mem_we    = w_wr;
  assign bus.mem_addr  = w_addr;
  assign bus.mem_wmask = bus.a_corrupt ? '0 : bus.a_mask;
  assign bus.mem_wdata = bus.a_data;

  assign w_unused_ok = ^{bus.a_param, bus.a_address[2:0]};
endmodule
